i2c_bus_sequencer: RTL and testbench
====================================

Name: i2c_bus_sequencer

Overview:
- Shares one i2c_master instance between NCH independent requesters (sensor/expander plugins) on the same bus.
- Arbitrates round-robin, drives the master's start/busy handshake and parameter inputs, and returns read data and status to the granted channel.
- Adds a launch timeout and an inter-transaction bus gap.
- Sits between the plugin request logic and i2c_master, in the clk domain.

Parameters:
- NCH, 4, number of requester channels (2..8).
- MAX_BITS, 64, write-data width per channel; matches i2c_master.
- MAX_DIN, 64, read-data width; matches i2c_master.
- GAP_CYCLES, 256, minimum clk cycles of idle between transactions.
- LAUNCH_TIMEOUT, 65535, clk cycles allowed for master busy to rise after start.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cfg_divider  in  32  bus clock divider passed to the master
- req_valid  in  NCH  per-channel transaction request (level, held until rsp)
- req_addr  in  NCH*7  7-bit slave address per channel
- req_rw  in  NCH  0=write, 1=read
- req_bytes  in  NCH*5  data byte count
- req_stop  in  NCH  issue STOP at end
- req_data  in  NCH*MAX_BITS  write data, MSB byte first
- grant  out  NCH  one-hot channel owning the bus
- rsp_valid  out  1  one-cycle completion pulse
- rsp_ch  out  $clog2(NCH)  channel index of completion
- rsp_data  out  MAX_DIN  read data captured from the master
- rsp_error  out  1  NACK reported by the master
- rsp_timeout  out  1  launch timeout
- m_start  out  1  to master start
- m_addr  out  7  to master set_addr
- m_rw  out  1  to master set_rw
- m_bytes  out  5  to master set_bytes
- m_stop  out  1  to master stop
- m_data_out  out  MAX_BITS  to master set_data_out
- m_divider  out  32  to master set_divider
- m_busy  in  1  from master busy
- m_error  in  1  from master error
- m_data_in  in  MAX_DIN  from master data_in

Behaviour:
- Reset values: all outputs 0; grant=0; rr pointer=0; state IDLE.
- m_busy and m_error pass through a 2-flop synchroniser, because the master runs on a divided clock.
- m_data_in is sampled only in the COMPLETE state, when it is stable.
- IDLE:
  - If any req_valid is set, select the first set bit at or after rr_ptr, wrapping around.
  - Register the index, set grant, latch m_* from that channel's slices, m_divider<=cfg_divider, go LAUNCH.
  - Selection uses req_valid as sampled in IDLE only; later changes have no effect.
- LAUNCH:
  - m_start=1; the timeout counter increments each clk.
  - When synchronised busy=1: m_start<=0, go WAIT.
  - If the counter reaches LAUNCH_TIMEOUT first: m_start<=0, rsp_timeout=1, go COMPLETE.
- WAIT: stay until synchronised busy=0, then go COMPLETE.
- COMPLETE (1 cycle):
  - rsp_valid=1, rsp_ch=index, rsp_data=m_data_in (0 on timeout), rsp_error=synchronised error.
  - rr_ptr<=index+1 mod NCH; grant<=0; go GAP.
- GAP: count GAP_CYCLES, then go IDLE.
  - Guarantees the master returns to its wait state and observes start low before the next transaction.
- A requester must drop req_valid within GAP_CYCLES after rsp_valid for its channel, or it is re-served.
- m_* parameter outputs hold stable from LAUNCH through COMPLETE.
- Simultaneous requests: round-robin order; no channel waits more than NCH-1 transactions.
- Latency: IDLE to m_start is 1 cycle.
- Reset mid-transaction: all state clears and m_start drops. The master is not reset by this block; it recovers by its own bus-free logic.

Optional Feature:
- Macro I2C_SEQ_RETRY_EN.
- With it: a NACK completion (rsp_error) is retried up to 2 additional times, passing through GAP each time, before rsp_valid is reported.
  - rsp_error is 1 only if the last attempt also NACKs.
  - An extra output rsp_retries (2 bits) reports the retries used.
- Without it: a single attempt, and the rsp_retries port is absent.

Decomposition:
- Package i2c_seq_pkg holds:
  - the state enum (IDLE, LAUNCH, WAIT, COMPLETE, GAP);
  - the RW_WRITE/RW_READ constants;
  - the default GAP_CYCLES and LAUNCH_TIMEOUT values.
- One sub-module, i2c_rr_arbiter: a combinational round-robin pick of a one-hot grant plus index from req_valid and rr_ptr, parameterised by NCH.

Test Plan:
- Bench setup: a behavioural i2c_master model on a divided clock; NCH=4, GAP_CYCLES=16.
- ch2 read (addr 0x48, 2 bytes), model returns 0xBEEF:
  - m_start is held until busy is seen.
  - Then rsp_valid=1, rsp_ch=2, rsp_data[15:0]=0xBEEF, rsp_error=0.
- ch0, ch1 and ch3 request simultaneously with rr_ptr=0: grants occur in order 0,1,3, each separated by at least 16 idle cycles.
- Model NACKs the address on ch1 write: rsp_error=1, rsp_ch=1. With I2C_SEQ_RETRY_EN: 3 starts are seen, then rsp_retries=2.
- Model never raises busy, LAUNCH_TIMEOUT=100: after 100 cycles, rsp_timeout=1, rsp_data=0 and m_start=0.
- rst_n is asserted during WAIT: all outputs are 0 immediately; after release, a pending ch3 request is served first from rr_ptr=0.
- Fairness: ch0 holds req_valid continuously while ch1 requests once; ch1 is served within 1 ch0 transaction.

Source files
------------

// File: rtl/i2c_seq_pkg.sv
// Shared types and defaults for the I2C bus sequencer.
package i2c_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LAUNCH   = 3'd1,
    WAIT     = 3'd2,
    COMPLETE = 3'd3,
    GAP      = 3'd4
  } seq_state_t;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam int DEF_GAP_CYCLES     = 256;
  localparam int DEF_LAUNCH_TIMEOUT = 65535;

endpackage

// File: rtl/i2c_rr_arbiter.sv
// Combinational round-robin pick: first requesting channel at or after rr_ptr, wrapping.
module i2c_rr_arbiter #(
  parameter int NCH = 4,
  parameter int IW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  rr_ptr,
  output logic [NCH-1:0] gnt,
  output logic [IW-1:0]  idx,
  output logic           any
);

  int c;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int i = 0; i < NCH; i++) begin
      c = (int'(rr_ptr) + i) % NCH;
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = c[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/i2c_bus_sequencer.sv
// Round-robin sequencer sharing one i2c_master between NCH requesters.
// Define I2C_SEQ_RETRY_EN to retry NACKed transactions up to twice and add rsp_retries.
module i2c_bus_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int NCH            = 4,
  parameter int MAX_BITS       = 64,
  parameter int MAX_DIN        = 64,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int LAUNCH_TIMEOUT = DEF_LAUNCH_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             cfg_divider,
  input  logic [NCH-1:0]          req_valid,
  input  logic [NCH*7-1:0]        req_addr,
  input  logic [NCH-1:0]          req_rw,
  input  logic [NCH*5-1:0]        req_bytes,
  input  logic [NCH-1:0]          req_stop,
  input  logic [NCH*MAX_BITS-1:0] req_data,
  output logic [NCH-1:0]          grant,
  output logic                    rsp_valid,
  output logic [$clog2(NCH)-1:0]  rsp_ch,
  output logic [MAX_DIN-1:0]      rsp_data,
  output logic                    rsp_error,
  output logic                    rsp_timeout,
`ifdef I2C_SEQ_RETRY_EN
  output logic [1:0]              rsp_retries,
`endif
  output logic                    m_start,
  output logic [6:0]              m_addr,
  output logic                    m_rw,
  output logic [4:0]              m_bytes,
  output logic                    m_stop,
  output logic [MAX_BITS-1:0]     m_data_out,
  output logic [31:0]             m_divider,
  input  logic                    m_busy,
  input  logic                    m_error,
  input  logic [MAX_DIN-1:0]      m_data_in,
  output seq_state_t              state_dbg
);

  localparam int IW = $clog2(NCH);

  seq_state_t     state;
  logic           busy_s1, busy_s2, err_s1, err_s2;
  logic [IW-1:0]  rr_ptr, cur_idx, pick_idx;
  logic [NCH-1:0] pick_gnt;
  logic           pick_any;
  logic [31:0]    to_cnt, gap_cnt;
  logic           timed_out;
  logic           retry_now, retry_pending;

  assign state_dbg = state;

  i2c_rr_arbiter #(.NCH(NCH), .IW(IW)) u_arb (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .gnt    (pick_gnt),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // The master runs on a divided clock, so its status is resynchronised here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_s1 <= 1'b0;
      busy_s2 <= 1'b0;
      err_s1  <= 1'b0;
      err_s2  <= 1'b0;
    end else begin
      busy_s1 <= m_busy;
      busy_s2 <= busy_s1;
      err_s1  <= m_error;
      err_s2  <= err_s1;
    end
  end

`ifdef I2C_SEQ_RETRY_EN
  logic [1:0] retry_cnt;
  assign retry_now     = err_s2 && !timed_out && (retry_cnt != 2'd2);
  assign retry_pending = (retry_cnt != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_cnt   <= 2'd0;
      rsp_retries <= 2'd0;
    end else if (state == COMPLETE) begin
      if (retry_now) begin
        retry_cnt <= retry_cnt + 2'd1;
      end else begin
        retry_cnt   <= 2'd0;
        rsp_retries <= retry_cnt;
      end
    end
  end
`else
  assign retry_now     = 1'b0;
  assign retry_pending = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      cur_idx     <= '0;
      grant       <= '0;
      rsp_valid   <= 1'b0;
      rsp_ch      <= '0;
      rsp_data    <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
      m_start     <= 1'b0;
      m_addr      <= '0;
      m_rw        <= 1'b0;
      m_bytes     <= '0;
      m_stop      <= 1'b0;
      m_data_out  <= '0;
      m_divider   <= '0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
      timed_out   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            cur_idx    <= pick_idx;
            grant      <= pick_gnt;
            m_addr     <= req_addr[pick_idx*7 +: 7];
            m_rw       <= req_rw[pick_idx];
            m_bytes    <= req_bytes[pick_idx*5 +: 5];
            m_stop     <= req_stop[pick_idx];
            m_data_out <= req_data[pick_idx*MAX_BITS +: MAX_BITS];
            m_divider  <= cfg_divider;
            m_start    <= 1'b1;
            to_cnt     <= '0;
            timed_out  <= 1'b0;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (busy_s2) begin
            m_start <= 1'b0;
            state   <= WAIT;
          end else if (to_cnt == 32'(LAUNCH_TIMEOUT - 1)) begin
            m_start   <= 1'b0;
            timed_out <= 1'b1;
            state     <= COMPLETE;
          end else begin
            to_cnt <= to_cnt + 32'd1;
          end
        end
        WAIT: begin
          if (!busy_s2) state <= COMPLETE;
        end
        COMPLETE: begin
          gap_cnt <= '0;
          state   <= GAP;
          // A retried NACK keeps the grant and the latched parameters for the next attempt.
          if (!retry_now) begin
            rsp_valid   <= 1'b1;
            rsp_ch      <= cur_idx;
            rsp_data    <= timed_out ? '0 : m_data_in;
            rsp_error   <= err_s2 & ~timed_out;
            rsp_timeout <= timed_out;
            rr_ptr      <= (cur_idx == IW'(NCH - 1)) ? '0 : cur_idx + 1'b1;
            grant       <= '0;
          end
        end
        GAP: begin
          if (gap_cnt == 32'(GAP_CYCLES - 1)) begin
            if (retry_pending) begin
              m_start   <= 1'b1;
              to_cnt    <= '0;
              timed_out <= 1'b0;
              state     <= LAUNCH;
            end else begin
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_bus_sequencer.sv
// Bench for i2c_bus_sequencer: behavioural i2c_master on a divided clock, round-robin reference model.
module tb_i2c_bus_sequencer;
  import i2c_seq_pkg::*;

  localparam int NCH = 4;
  localparam int MAX_BITS = 64;
  localparam int MAX_DIN = 64;
  localparam int GAP = 16;
  localparam int LTO = 100;
  localparam int EW = 69;
  localparam int SW = 110;
  localparam int AW = 187;

  logic clk = 1'b0;
  logic mclk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  always #20 mclk = ~mclk;

  logic [31:0]             cfg_divider;
  logic [NCH-1:0]          req_valid;
  logic [NCH*7-1:0]        req_addr;
  logic [NCH-1:0]          req_rw;
  logic [NCH*5-1:0]        req_bytes;
  logic [NCH-1:0]          req_stop;
  logic [NCH*MAX_BITS-1:0] req_data;
  logic [NCH-1:0]          grant;
  logic                    rsp_valid;
  logic [1:0]              rsp_ch;
  logic [MAX_DIN-1:0]      rsp_data;
  logic                    rsp_error;
  logic                    rsp_timeout;
  logic                    m_start;
  logic [6:0]              m_addr;
  logic                    m_rw;
  logic [4:0]              m_bytes;
  logic                    m_stop;
  logic [MAX_BITS-1:0]     m_data_out;
  logic [31:0]             m_divider;
  logic                    m_busy;
  logic                    m_error;
  logic [MAX_DIN-1:0]      m_data_in;
  seq_state_t              state_dbg;
`ifdef I2C_SEQ_RETRY_EN
  logic [1:0]              rsp_retries;
`endif

  logic [6:0]          ch_addr [NCH];
  logic [4:0]          ch_bytes[NCH];
  logic [MAX_BITS-1:0] ch_data [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_pack
    assign req_addr[g*7 +: 7]               = ch_addr[g];
    assign req_bytes[g*5 +: 5]              = ch_bytes[g];
    assign req_data[g*MAX_BITS +: MAX_BITS] = ch_data[g];
  end

  i2c_bus_sequencer #(
    .NCH(NCH), .MAX_BITS(MAX_BITS), .MAX_DIN(MAX_DIN),
    .GAP_CYCLES(GAP), .LAUNCH_TIMEOUT(LTO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_divider(cfg_divider),
    .req_valid(req_valid), .req_addr(req_addr), .req_rw(req_rw),
    .req_bytes(req_bytes), .req_stop(req_stop), .req_data(req_data),
    .grant(grant), .rsp_valid(rsp_valid), .rsp_ch(rsp_ch), .rsp_data(rsp_data),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
`ifdef I2C_SEQ_RETRY_EN
    .rsp_retries(rsp_retries),
`endif
    .m_start(m_start), .m_addr(m_addr), .m_rw(m_rw), .m_bytes(m_bytes),
    .m_stop(m_stop), .m_data_out(m_data_out), .m_divider(m_divider),
    .m_busy(m_busy), .m_error(m_error), .m_data_in(m_data_in),
    .state_dbg(state_dbg)
  );

  logic [AW-1:0] all_out;
  logic [SW-1:0] m_params;
  assign all_out = {grant, rsp_valid, rsp_ch, rsp_data, rsp_error, rsp_timeout, m_start,
                    m_addr, m_rw, m_bytes, m_stop, m_data_out, m_divider, state_dbg};
  assign m_params = {m_addr, m_rw, m_bytes, m_stop, m_data_out, m_divider};

  int checks = 0;
  int errors = 0;
  int ref_ptr = 0;
  logic [EW-1:0] exp_q[$];

  // ---------------- behavioural master ----------------
  bit model_nack = 1'b0;
  bit model_nobusy = 1'b0;
  logic [63:0] model_rdata = '0;

  initial begin
    m_busy = 1'b0;
    m_error = 1'b0;
    m_data_in = '0;
    forever begin
      @(posedge mclk);
      if (m_start && !model_nobusy) begin
        @(posedge mclk);
        m_busy = 1'b1;
        m_error = 1'b0;
        repeat (2 + int'(m_bytes)) @(posedge mclk);
        m_error = model_nack;
        if (m_rw) m_data_in = model_rdata;
        @(posedge mclk);
        m_busy = 1'b0;
        while (m_start) @(posedge mclk);
      end
    end
  end

  // ---------------- cycle counter and m_start monitor ----------------
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int start_cnt = 0;
  int last_rise_cyc = 0;
  int last_len = 0;
  int run_len = 0;
  bit fall_busy = 1'b0;
  bit prev_start = 1'b0;
  initial forever begin
    @(negedge clk);
    if (m_start && !prev_start) begin
      start_cnt++;
      last_rise_cyc = cyc;
    end
    if (!m_start && prev_start) begin
      last_len = run_len;
      fall_busy = m_busy;
    end
    run_len = m_start ? run_len + 1 : 0;
    prev_start = m_start;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic int rr_pick(input logic [NCH-1:0] m, input int p);
    for (int k = 0; k < NCH; k++)
      if (m[(p + k) % NCH]) return (p + k) % NCH;
    return -1;
  endfunction

  task automatic serve_one(input bit hold0, output int got, output int rise_c, output int rsp_c);
    logic [EW-1:0] e;
    logic [NCH-1:0] gseen, one;
    logic [SW-1:0] snap, exp_snap;
    int c;
    bit ok, have_snap, unstable;
    c = rr_pick(req_valid, ref_ptr);
    exp_q.push_back({(model_nobusy | req_rw[c]), 2'(c), (model_nack & ~model_nobusy),
                     model_nobusy, (model_nobusy ? 64'd0 : model_rdata)});
    exp_snap = {ch_addr[c], req_rw[c], ch_bytes[c], req_stop[c], ch_data[c], cfg_divider};
    ok = 1'b0; have_snap = 1'b0; unstable = 1'b0; gseen = '0; snap = '0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(negedge clk);
      if (grant != '0) begin
        gseen = grant;
        if (!have_snap) snap = m_params;
        else if (m_params !== snap) unstable = 1'b1;
        have_snap = 1'b1;
      end
      if (rsp_valid) ok = 1'b1;
    end
    e = exp_q.pop_front();
    got = -1; rise_c = last_rise_cyc; rsp_c = cyc;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rsp_wait: no rsp_valid within 3000 cycles, want ch %0d", c);
      return;
    end
    got = int'(rsp_ch);
    if (rsp_ch !== e[67:66]) begin
      errors++; $display("FAIL rsp_ch: got %0d want %0d", rsp_ch, e[67:66]);
    end
    checks++;
    if (rsp_error !== e[65]) begin
      errors++; $display("FAIL rsp_error: got %0b want %0b (ch %0d)", rsp_error, e[65], c);
    end
    checks++;
    if (rsp_timeout !== e[64]) begin
      errors++; $display("FAIL rsp_timeout: got %0b want %0b (ch %0d)", rsp_timeout, e[64], c);
    end
    if (e[68]) begin
      checks++;
      if (rsp_data !== e[63:0]) begin
        errors++; $display("FAIL rsp_data: got %h want %h (ch %0d)", rsp_data, e[63:0], c);
      end
    end
    one = '0; one[c] = 1'b1;
    checks++;
    if (gseen !== one) begin
      errors++; $display("FAIL grant: got %b want %b", gseen, one);
    end
    checks++;
    if (snap !== exp_snap || unstable) begin
      errors++; $display("FAIL m_params: got %h want %h unstable=%0b", snap, exp_snap, unstable);
    end
    checks++;
    if (m_start !== 1'b0) begin
      errors++; $display("FAIL m_start_at_rsp: got %0b want 0", m_start);
    end
    ref_ptr = (c + 1) % NCH;
    if (!(hold0 && c == 0)) req_valid[c] = 1'b0;
  endtask

  task automatic set_ch(input int c, input logic rw, input logic [6:0] a, input logic [4:0] b);
    ch_addr[c] = a;
    req_rw[c] = rw;
    ch_bytes[c] = b;
    req_stop[c] = 1'($urandom_range(0, 1));
    ch_data[c] = {$urandom, $urandom};
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    cfg_divider = 32'd25;
    req_valid = '1;
    for (int i = 0; i < NCH; i++) set_ch(i, RW_WRITE, 7'h10, 5'd1);
    repeat (4) @(negedge clk);
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", all_out);
    end
`ifdef I2C_SEQ_RETRY_EN
    checks++;
    if (rsp_retries !== 2'd0) begin
      errors++; $display("FAIL reset_retries: got %0d want 0", rsp_retries);
    end
`endif
    req_valid = '0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_round_robin();
    int order[3] = '{0, 1, 3};
    int g, rise_c, rsp_c, prev_rsp;
    for (int i = 0; i < NCH; i++) set_ch(i, RW_READ, 7'($urandom_range(0, 127)), 5'($urandom_range(1, 3)));
    model_rdata = {$urandom, $urandom} | 64'd1;
    req_valid = 4'b1011;
    prev_rsp = 0;
    for (int i = 0; i < 3; i++) begin
      serve_one(1'b0, g, rise_c, rsp_c);
      checks++;
      if (g != order[i]) begin
        errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, g, order[i]);
      end
      if (i > 0) begin
        checks++;
        if (rise_c - prev_rsp < GAP) begin
          errors++; $display("FAIL rr_gap[%0d]: got %0d cycles want >= %0d", i, rise_c - prev_rsp, GAP);
        end
      end
      prev_rsp = rsp_c;
      model_rdata = {$urandom, $urandom} | 64'd1;
    end
  endtask

  task automatic test_read();
    int g, rise_c, rsp_c;
    set_ch(2, RW_READ, 7'h48, 5'd2);
    model_rdata = 64'hBEEF;
    req_valid[2] = 1'b1;
    serve_one(1'b0, g, rise_c, rsp_c);
    checks++;
    if (fall_busy !== 1'b1) begin
      errors++; $display("FAIL read_start_hold: busy at m_start fall got %0b want 1", fall_busy);
    end
    checks++;
    if (rsp_data[15:0] !== 16'hBEEF) begin
      errors++; $display("FAIL read_data16: got %h want beef", rsp_data[15:0]);
    end
  endtask

  task automatic test_timeout();
    int g, rise_c, rsp_c;
    model_nobusy = 1'b1;
    set_ch(0, RW_READ, 7'h22, 5'd1);
    req_valid[0] = 1'b1;
    serve_one(1'b0, g, rise_c, rsp_c);
    checks++;
    if (last_len < LTO - 1 || last_len > LTO + 1) begin
      errors++; $display("FAIL timeout_len: m_start high %0d cycles want %0d", last_len, LTO);
    end
    model_nobusy = 1'b0;
  endtask

  task automatic test_nack();
    int g, rise_c, rsp_c, s0, want;
    model_nack = 1'b1;
    set_ch(1, RW_WRITE, 7'($urandom_range(0, 127)), 5'd3);
    req_valid[1] = 1'b1;
    s0 = start_cnt;
    serve_one(1'b0, g, rise_c, rsp_c);
`ifdef I2C_SEQ_RETRY_EN
    want = 3;
    checks++;
    if (rsp_retries !== 2'd2) begin
      errors++; $display("FAIL nack_retries: got %0d want 2", rsp_retries);
    end
`else
    want = 1;
`endif
    checks++;
    if (start_cnt - s0 != want) begin
      errors++; $display("FAIL nack_starts: got %0d want %0d", start_cnt - s0, want);
    end
    model_nack = 1'b0;
  endtask

  task automatic test_reset_mid();
    int g, rise_c, rsp_c;
    bit seen;
    set_ch(1, RW_WRITE, 7'h31, 5'd6);
    set_ch(3, RW_READ, 7'h33, 5'd2);
    req_valid[1] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 500 && !seen; k++) begin
      @(negedge clk);
      seen = m_busy;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL mid_busy: master busy got 0 want 1");
    end
    repeat (4) @(negedge clk);
    req_valid[3] = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL mid_reset_outputs: got %h want 0", all_out);
    end
    ref_ptr = 0;
    req_valid[1] = 1'b0;
    for (int k = 0; k < 500 && m_busy; k++) @(negedge clk);
    repeat (10) @(negedge clk);
    model_rdata = {$urandom, $urandom};
    rst_n = 1'b1;
    serve_one(1'b0, g, rise_c, rsp_c);
    checks++;
    if (g != 3) begin
      errors++; $display("FAIL mid_first_ch: got %0d want 3", g);
    end
  endtask

  task automatic test_fairness();
    int g, rise_c, rsp_c, n0;
    bit served;
    set_ch(0, RW_WRITE, 7'h50, 5'd1);
    set_ch(1, RW_WRITE, 7'h51, 5'd1);
    req_valid[0] = 1'b1;
    serve_one(1'b1, g, rise_c, rsp_c);
    req_valid[1] = 1'b1;
    n0 = 0; served = 1'b0;
    for (int k = 0; k < 3 && !served; k++) begin
      serve_one(1'b1, g, rise_c, rsp_c);
      if (g == 1) served = 1'b1;
      else n0++;
    end
    req_valid[0] = 1'b0;
    checks++;
    if (!served || n0 > 1) begin
      errors++; $display("FAIL fairness: ch1 served=%0b after %0d ch0 txns want <= 1", served, n0);
    end
  endtask

  task automatic test_random();
    int g, rise_c, rsp_c;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NCH; i++)
        set_ch(i, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), 5'($urandom_range(1, 6)));
      cfg_divider = $urandom;
      model_rdata = {$urandom, $urandom};
      req_valid = 4'($urandom_range(1, 15));
      for (int k = 0; k < 8 && req_valid != '0; k++) begin
        serve_one(1'b0, g, rise_c, rsp_c);
        model_rdata = {$urandom, $urandom};
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_read();
    test_timeout();
    test_nack();
    test_reset_mid();
    test_fairness();
    test_random();
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
